// File: rtl/rv32_decode_unit_pkg.sv
// Shared constants for the RV32I decode stage: opcode[6:2] classes,
// ALU/memory opcode encodings and the immediate-format selector.
package rv32_decode_unit_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'd0;
    localparam logic [4:0] OPC_OP_IMM = 5'd4;
    localparam logic [4:0] OPC_AUIPC  = 5'd5;
    localparam logic [4:0] OPC_STORE  = 5'd8;
    localparam logic [4:0] OPC_OP     = 5'd12;
    localparam logic [4:0] OPC_LUI    = 5'd13;
    localparam logic [4:0] OPC_BRANCH = 5'd24;
    localparam logic [4:0] OPC_JALR   = 5'd25;
    localparam logic [4:0] OPC_JAL    = 5'd27;

    // Upper bits are shifter/compare one-hots, low three bits drive the 74x381
    localparam logic [7:0] ALU_NONE = 8'h00;
    localparam logic [7:0] ALU_SLT  = 8'h80;
    localparam logic [7:0] ALU_SLTU = 8'h40;
    localparam logic [7:0] ALU_SLL  = 8'h20;
    localparam logic [7:0] ALU_SRL  = 8'h10;
    localparam logic [7:0] ALU_SRA  = 8'h08;
    localparam logic [7:0] ALU_SUB  = 8'h02;
    localparam logic [7:0] ALU_ADD  = 8'h03;
    localparam logic [7:0] ALU_XOR  = 8'h04;
    localparam logic [7:0] ALU_OR   = 8'h05;
    localparam logic [7:0] ALU_AND  = 8'h06;

    localparam logic [7:0] MEM_NONE = 8'h00;
    localparam logic [7:0] MEM_LB   = 8'h80;
    localparam logic [7:0] MEM_LH   = 8'h40;
    localparam logic [7:0] MEM_LW   = 8'h20;
    localparam logic [7:0] MEM_LBU  = 8'h10;
    localparam logic [7:0] MEM_LHU  = 8'h08;
    localparam logic [7:0] MEM_SB   = 8'h04;
    localparam logic [7:0] MEM_SH   = 8'h02;
    localparam logic [7:0] MEM_SW   = 8'h01;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_U    = 3'd1,
        IMM_J    = 3'd2,
        IMM_I    = 3'd3,
        IMM_B    = 3'd4,
        IMM_S    = 3'd5
    } imm_sel_e;

    // Register-register and register-immediate arithmetic share one table;
    // only register ops honour inst[30] as the sub selector.
    function automatic logic [7:0] alu_sel(input logic [2:0] f3, input logic alt, input logic is_reg);
        logic [7:0] sel;
        case (f3)
            3'd0:    sel = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'd1:    sel = ALU_SLL;
            3'd2:    sel = ALU_SLT;
            3'd3:    sel = ALU_SLTU;
            3'd4:    sel = ALU_XOR;
            3'd5:    sel = alt ? ALU_SRA : ALU_SRL;
            3'd6:    sel = ALU_OR;
            3'd7:    sel = ALU_AND;
            default: sel = ALU_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/rv32_decode_unit_if.sv
// Fetch-to-decode bundle: instruction/operand inputs and decoded control outputs.
interface rv32_decode_unit_if;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] qa;
    logic        is_lt;
    logic        is_ltu;
    logic        is_zero;
    logic        brh;
    logic [31:0] brh_addr;
    logic        alu_src_1;
    logic        alu_src_2;
    logic [31:0] alu_imm_1;
    logic [31:0] alu_imm_2;
    logic [7:0]  alu_op;
    logic [7:0]  mem_op;
    logic        reg_we;
    logic        load;
    logic        store;

    modport master (
        output pc, inst, qa, is_lt, is_ltu, is_zero,
        input  brh, brh_addr, alu_src_1, alu_src_2, alu_imm_1, alu_imm_2,
               alu_op, mem_op, reg_we, load, store
    );

    modport slave (
        input  pc, inst, qa, is_lt, is_ltu, is_zero,
        output brh, brh_addr, alu_src_1, alu_src_2, alu_imm_1, alu_imm_2,
               alu_op, mem_op, reg_we, load, store
    );
endinterface

// File: rtl/rv32_decode_unit_imm_gen.sv
// Immediate generator: assembles the U/J/I/B/S formats from the upper
// instruction bits and picks one by the decoded format selector.
module rv32_imm_gen
    import rv32_decode_unit_pkg::*;
(
    input  logic [31:7] inst,
    input  imm_sel_e    sel,
    output logic [31:0] imm
);

    // Format mux; unrecognised formats yield zero
    always_comb begin
        imm = 32'd0;
        case (sel)
            IMM_U:   imm = {inst[31:12], 12'd0};
            IMM_J:   imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_B:   imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv32_decode_unit.sv
// RV32I decode stage: instruction classification, ALU/memory opcodes,
// operand selection and jump/branch resolution. Purely combinational.
module rv32_decode_unit
    import rv32_decode_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    rv32_decode_unit_if.slave  bus
);

    logic [4:0]  opc_s;
    logic [2:0]  f3_s;
    logic        is_load_s, is_op_imm_s, is_auipc_s, is_store_s, is_op_s;
    logic        is_lui_s, is_branch_s, is_jalr_s, is_jal_s;
    imm_sel_e    imm_sel_s;
    logic [31:0] imm_s;
    logic [31:0] target_s;
    logic        brh_raw_s, cond_s;
    logic [7:0]  alu_op_raw_s, mem_op_raw_s;
    logic        unused_s;

    assign opc_s = bus.inst[6:2];
    assign f3_s  = bus.inst[14:12];

    assign is_load_s   = (opc_s == OPC_LOAD);
    assign is_op_imm_s = (opc_s == OPC_OP_IMM);
    assign is_auipc_s  = (opc_s == OPC_AUIPC);
    assign is_store_s  = (opc_s == OPC_STORE);
    assign is_op_s     = (opc_s == OPC_OP);
    assign is_lui_s    = (opc_s == OPC_LUI);
    assign is_branch_s = (opc_s == OPC_BRANCH);
    assign is_jalr_s   = (opc_s == OPC_JALR);
    assign is_jal_s    = (opc_s == OPC_JAL);

    // Immediate format selection by instruction class
    always_comb begin
        imm_sel_s = IMM_NONE;
        case (opc_s)
            OPC_LUI, OPC_AUIPC:              imm_sel_s = IMM_U;
            OPC_JAL:                         imm_sel_s = IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM:  imm_sel_s = IMM_I;
            OPC_BRANCH:                      imm_sel_s = IMM_B;
            OPC_STORE:                       imm_sel_s = IMM_S;
            default:                         imm_sel_s = IMM_NONE;
        endcase
    end

    rv32_imm_gen u_imm_gen (
        .inst (bus.inst[31:7]),
        .sel  (imm_sel_s),
        .imm  (imm_s)
    );

    // Target is computed for every class so it is ready before brh resolves
    assign target_s = (is_jalr_s ? bus.qa : bus.pc) + imm_s;

    assign bus.brh_addr  = {target_s[31:1], 1'b0};
    assign bus.alu_src_1 = is_load_s | is_store_s | is_op_imm_s | is_op_s | is_branch_s;
    assign bus.alu_src_2 = is_op_s | is_branch_s;
    assign bus.alu_imm_1 = (is_auipc_s | is_jal_s | is_jalr_s) ? bus.pc : 32'd0;
    assign bus.alu_imm_2 = (is_jal_s | is_jalr_s) ? 32'd4 : imm_s;

    // Branch condition from the ALU compare flags; f3 2/3 are reserved
    always_comb begin
        cond_s = 1'b0;
        case (f3_s)
            3'd0:    cond_s = bus.is_zero;
            3'd1:    cond_s = !bus.is_zero;
            3'd4:    cond_s = bus.is_lt;
            3'd5:    cond_s = !bus.is_lt;
            3'd6:    cond_s = bus.is_ltu;
            3'd7:    cond_s = !bus.is_ltu;
            default: cond_s = 1'b0;
        endcase
    end

    assign brh_raw_s = is_jal_s | is_jalr_s | (is_branch_s & cond_s);

    // ALU and memory opcode generation
    always_comb begin
        alu_op_raw_s = ALU_NONE;
        mem_op_raw_s = MEM_NONE;
        if (is_op_s || is_op_imm_s) begin
            alu_op_raw_s = alu_sel(f3_s, bus.inst[30], is_op_s);
        end else if (is_branch_s) begin
            alu_op_raw_s = ALU_SUB;
        end else if (is_lui_s || is_auipc_s || is_jal_s || is_jalr_s || is_load_s || is_store_s) begin
            alu_op_raw_s = ALU_ADD;
        end else begin
            alu_op_raw_s = ALU_NONE;
        end
        if (is_load_s) begin
            case (f3_s)
                3'd0:    mem_op_raw_s = MEM_LB;
                3'd1:    mem_op_raw_s = MEM_LH;
                3'd2:    mem_op_raw_s = MEM_LW;
                3'd4:    mem_op_raw_s = MEM_LBU;
                3'd5:    mem_op_raw_s = MEM_LHU;
                default: mem_op_raw_s = MEM_NONE;
            endcase
        end else if (is_store_s) begin
            case (f3_s)
                3'd0:    mem_op_raw_s = MEM_SB;
                3'd1:    mem_op_raw_s = MEM_SH;
                3'd2:    mem_op_raw_s = MEM_SW;
                default: mem_op_raw_s = MEM_NONE;
            endcase
        end else begin
            mem_op_raw_s = MEM_NONE;
        end
    end

    // Reset masks only the side-effecting controls; data paths keep flowing
    always_comb begin
        if (rst) begin
            bus.brh    = brh_raw_s;
            bus.alu_op = alu_op_raw_s;
            bus.mem_op = mem_op_raw_s;
            bus.reg_we = is_lui_s | is_auipc_s | is_jal_s | is_jalr_s | is_load_s | is_op_imm_s | is_op_s;
            bus.load   = is_load_s;
            bus.store  = is_store_s;
        end else begin
            bus.brh    = 1'b0;
            bus.alu_op = 8'h00;
            bus.mem_op = 8'h00;
            bus.reg_we = 1'b0;
            bus.load   = 1'b0;
            bus.store  = 1'b0;
        end
    end

    assign unused_s = clk ^ (^bus.inst[1:0]) ^ target_s[0];

endmodule

// File: tb/tb_rv32_decode_unit.sv
// Directed scoreboard bench for rv32_decode_unit: each step pushes its
// expected decode, then pops and compares against the DUT outputs.
module tb_rv32_decode_unit;

    typedef struct {
        logic        brh;
        logic [31:0] addr;
        logic        s1;
        logic        s2;
        logic [31:0] i1;
        logic [31:0] i2;
        logic [7:0]  aop;
        logic [7:0]  mop;
        logic        we;
        logic        ld;
        logic        st;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   applied = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    rv32_decode_unit_if bus ();

    rv32_decode_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        applied++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] p, input logic [31:0] i,
                         input logic [31:0] q, input logic z, input logic lt, input logic ltu);
        rst         = r;
        bus.pc      = p;
        bus.inst    = i;
        bus.qa      = q;
        bus.is_zero = z;
        bus.is_lt   = lt;
        bus.is_ltu  = ltu;
    endtask

    task automatic push(input logic b, input logic [31:0] a, input logic s1, input logic s2,
                        input logic [31:0] i1, input logic [31:0] i2, input logic [7:0] aop,
                        input logic [7:0] mop, input logic we, input logic ld, input logic st);
        exp_t e;
        e.brh = b; e.addr = a; e.s1 = s1; e.s2 = s2; e.i1 = i1; e.i2 = i2;
        e.aop = aop; e.mop = mop; e.we = we; e.ld = ld; e.st = st;
        sb_q.push_back(e);
    endtask

    task automatic check(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            applied++;
            miscompares++;
            $error("FAIL %s observed=empty-scoreboard expected=entry", name);
        end else begin
            e = sb_q.pop_front();
            cmp({name, ".brh"},       {31'd0, bus.brh},       {31'd0, e.brh});
            cmp({name, ".brh_addr"},  bus.brh_addr,           e.addr);
            cmp({name, ".alu_src_1"}, {31'd0, bus.alu_src_1}, {31'd0, e.s1});
            cmp({name, ".alu_src_2"}, {31'd0, bus.alu_src_2}, {31'd0, e.s2});
            cmp({name, ".alu_imm_1"}, bus.alu_imm_1,          e.i1);
            cmp({name, ".alu_imm_2"}, bus.alu_imm_2,          e.i2);
            cmp({name, ".alu_op"},    {24'd0, bus.alu_op},    {24'd0, e.aop});
            cmp({name, ".mem_op"},    {24'd0, bus.mem_op},    {24'd0, e.mop});
            cmp({name, ".reg_we"},    {31'd0, bus.reg_we},    {31'd0, e.we});
            cmp({name, ".load"},      {31'd0, bus.load},      {31'd0, e.ld});
            cmp({name, ".store"},     {31'd0, bus.store},     {31'd0, e.st});
        end
    endtask

    // Drive just after a rising edge, compare on the following falling edge
    task automatic step(input string name, input logic [31:0] p, input logic [31:0] i,
                        input logic [31:0] q, input logic z, input logic lt, input logic ltu,
                        input logic b, input logic [31:0] a, input logic s1, input logic s2,
                        input logic [31:0] i1, input logic [31:0] i2, input logic [7:0] aop,
                        input logic [7:0] mop, input logic we, input logic ld, input logic st);
        @(posedge clk);
        #1;
        drive(1'b1, p, i, q, z, lt, ltu);
        push(b, a, s1, s2, i1, i2, aop, mop, we, ld, st);
        @(negedge clk);
        check(name);
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        // Reset with an all-zero word: it decodes as lb, but controls stay masked
        #1;
        push(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset0");
        repeat (2) @(posedge clk);

        step("add",   32'h0, 32'h002081B3, 32'h0, 1'b0, 1'b0, 1'b0,
             1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0);
        step("sub",   32'h0, 32'h402081B3, 32'h0, 1'b0, 1'b0, 1'b0,
             1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0);
        step("add_lo00", 32'h0, 32'h002081B0, 32'h0, 1'b0, 1'b0, 1'b0,
             1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0);
        step("slt",   32'h0, 32'h0020A1B3, 32'h0, 1'b0, 1'b0, 1'b0,
             1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0);
        step("srai",  32'h0, 32'h4030D093, 32'h0, 1'b0, 1'b0, 1'b0,
             1'b0, 32'h402, 1'b1, 1'b0, 32'h0, 32'h403, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0);
        step("addi_neg", 32'h0, 32'hC0008093, 32'h0, 1'b0, 1'b0, 1'b0,
             1'b0, 32'hFFFFFC00, 1'b1, 1'b0, 32'h0, 32'hFFFFFC00, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0);
        step("lw",    32'h0, 32'h0080A283, 32'h0, 1'b0, 1'b0, 1'b0,
             1'b0, 32'h8, 1'b1, 1'b0, 32'h0, 32'h8, 8'h03, 8'h20, 1'b1, 1'b1, 1'b0);
        step("lbu",   32'h0, 32'h0000C283, 32'h0, 1'b0, 1'b0, 1'b0,
             1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 8'h03, 8'h10, 1'b1, 1'b1, 1'b0);
        step("sw",    32'h0, 32'h0020A423, 32'h0, 1'b0, 1'b0, 1'b0,
             1'b0, 32'h8, 1'b1, 1'b0, 32'h0, 32'h8, 8'h03, 8'h01, 1'b0, 1'b0, 1'b1);
        step("lui",   32'h0, 32'h123450B7, 32'h0, 1'b0, 1'b0, 1'b0,
             1'b0, 32'h12345000, 1'b0, 1'b0, 32'h0, 32'h12345000, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0);
        step("auipc", 32'h1000, 32'h12345097, 32'h0, 1'b0, 1'b0, 1'b0,
             1'b0, 32'h12346000, 1'b0, 1'b0, 32'h1000, 32'h12345000, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0);
        step("jal",   32'h100, 32'h010000EF, 32'h0, 1'b0, 1'b0, 1'b0,
             1'b1, 32'h110, 1'b0, 1'b0, 32'h100, 32'h4, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0);
        step("jalr",  32'h100, 32'h00508067, 32'h200, 1'b0, 1'b0, 1'b0,
             1'b1, 32'h204, 1'b0, 1'b0, 32'h100, 32'h4, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0);

        // Branches at pc 0x40 with offset -8; flags set so only the tested one matters
        step("beq_t",  32'h40, 32'hFE208CE3, 32'h0, 1'b1, 1'b1, 1'b1,
             1'b1, 32'h38, 1'b1, 1'b1, 32'h0, 32'hFFFFFFF8, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
        step("beq_n",  32'h40, 32'hFE208CE3, 32'h0, 1'b0, 1'b1, 1'b1,
             1'b0, 32'h38, 1'b1, 1'b1, 32'h0, 32'hFFFFFFF8, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
        step("bne_t",  32'h40, 32'hFE209CE3, 32'h0, 1'b0, 1'b0, 1'b0,
             1'b1, 32'h38, 1'b1, 1'b1, 32'h0, 32'hFFFFFFF8, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
        step("blt_t",  32'h40, 32'hFE20CCE3, 32'h0, 1'b0, 1'b1, 1'b0,
             1'b1, 32'h38, 1'b1, 1'b1, 32'h0, 32'hFFFFFFF8, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
        step("blt_n",  32'h40, 32'hFE20CCE3, 32'h0, 1'b1, 1'b0, 1'b1,
             1'b0, 32'h38, 1'b1, 1'b1, 32'h0, 32'hFFFFFFF8, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
        step("bge_t",  32'h40, 32'hFE20DCE3, 32'h0, 1'b0, 1'b0, 1'b1,
             1'b1, 32'h38, 1'b1, 1'b1, 32'h0, 32'hFFFFFFF8, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
        step("bge_n",  32'h40, 32'hFE20DCE3, 32'h0, 1'b1, 1'b1, 1'b0,
             1'b0, 32'h38, 1'b1, 1'b1, 32'h0, 32'hFFFFFFF8, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
        step("bltu_t", 32'h40, 32'hFE20ECE3, 32'h0, 1'b0, 1'b0, 1'b1,
             1'b1, 32'h38, 1'b1, 1'b1, 32'h0, 32'hFFFFFFF8, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
        step("bltu_n", 32'h40, 32'hFE20ECE3, 32'h0, 1'b1, 1'b1, 1'b0,
             1'b0, 32'h38, 1'b1, 1'b1, 32'h0, 32'hFFFFFFF8, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
        step("bgeu_t", 32'h40, 32'hFE20FCE3, 32'h0, 1'b1, 1'b1, 1'b0,
             1'b1, 32'h38, 1'b1, 1'b1, 32'h0, 32'hFFFFFFF8, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
        step("bgeu_n", 32'h40, 32'hFE20FCE3, 32'h0, 1'b0, 1'b0, 1'b1,
             1'b0, 32'h38, 1'b1, 1'b1, 32'h0, 32'hFFFFFFF8, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
        step("bf3_2",  32'h40, 32'hFE20ACE3, 32'h0, 1'b1, 1'b1, 1'b1,
             1'b0, 32'h38, 1'b1, 1'b1, 32'h0, 32'hFFFFFFF8, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
        step("unknown", 32'h80, 32'h0000007F, 32'h0, 1'b1, 1'b1, 1'b1,
             1'b0, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset asserted and released mid-phase, no clock edge in between
        @(posedge clk);
        #1;
        drive(1'b0, 32'h100, 32'h010000EF, 32'h0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 32'h110, 1'b0, 1'b0, 32'h100, 32'h4, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_jal");
        rst = 1'b1;
        push(1'b1, 32'h110, 1'b0, 1'b0, 32'h100, 32'h4, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0);
        #1;
        check("rel_jal");
        rst = 1'b0;
        bus.inst = 32'h0080A283;
        bus.pc   = 32'h0;
        push(1'b0, 32'h8, 1'b1, 1'b0, 32'h0, 32'h8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_lw");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/rv32_decode_unit.md
# rv32_decode_unit

Combinational RV32I instruction-decode stage of the homebrew RISC-V core, sitting between fetch and the ALU/memory stages. It classifies the fetched instruction and generates its immediate. It drives ALU operand selection and a one-hot-style ALU/memory opcode. It also resolves jumps and conditional branches, using comparison flags fed back from the ALU, and computes the branch target.

## Interface
- No parameters.
- clk  input  1  system clock; unused by the combinational logic, present for stage uniformity.
- rst  input  1  asynchronous, active-low reset.
- pc  input  32  address of the instruction being decoded.
- inst  input  32  instruction word.
- qa  input  32  rs1 read data, used as the jalr base.
- is_lt, is_ltu, is_zero  input  1 each  ALU flags for rs1−rs2: signed less-than, unsigned less-than, equal.
- brh  output  1  take jump/branch.
- brh_addr  output  32  target address, bit 0 forced to 0.
- alu_src_1  output  1  1 = qa, 0 = alu_imm_1.
- alu_src_2  output  1  1 = qb, 0 = alu_imm_2.
- alu_imm_1, alu_imm_2  output  32  ALU immediate operands.
- alu_op  output  8  [7] slt, [6] sltu, [5] sll, [4] srl, [3] sra, [2:0] 74x381 select (2 = A−B, 3 = A+B, 4 = xor, 5 = or, 6 = and).
- mem_op  output  8  [7] lb, [6] lh, [5] lw, [4] lbu, [3] lhu, [2] sb, [1] sh, [0] sw.
- reg_we, load, store  output  1 each  register write, load, and store class flags.

## Operation
- Class decode uses inst[6:2] only; inst[1:0] is ignored.
  - 0 load, 4 op-imm, 5 auipc, 8 store, 12 op, 13 lui, 24 branch, 25 jalr, 27 jal.
  - Any other value belongs to no class.
- Immediates:
  - U = {inst[31:12], 12'b0} for lui and auipc.
  - J = sext{inst[31], inst[19:12], inst[20], inst[30:21], 0} for jal.
  - I = sext inst[31:20] for jalr, load, and op-imm.
  - B = sext{inst[31], inst[7], inst[30:25], inst[11:8], 0} for branch.
  - S = sext{inst[31:25], inst[11:7]} for store.
  - imm = 0 otherwise.
- alu_src_1 = load|store|op-imm|op|branch.
- alu_src_2 = op|branch.
- alu_imm_1 = pc for auipc/jal/jalr, else 0.
- alu_imm_2 = 4 for jal/jalr, else imm.
- alu_op:
  - op, selected by funct3 with inst[30]:
    - f3 0: 0x03 (add), or 0x02 when inst[30] = 1 (sub).
    - f3 1: 0x20; 2: 0x80; 3: 0x40; 4: 0x04.
    - f3 5: 0x10 (srl), or 0x08 when inst[30] = 1 (sra).
    - f3 6: 0x05; 7: 0x06.
  - op-imm: same table, except f3 0 is always 0x03.
  - branch: 0x02.
  - lui/auipc/jal/jalr/load/store: 0x03.
  - Unknown opcode: 0x00.
- mem_op:
  - load: f3 0→0x80, 1→0x40, 2→0x20, 4→0x10, 5→0x08, otherwise 0.
  - store: f3 0→0x04, 1→0x02, 2→0x01, otherwise 0.
  - Any other class: 0.
- reg_we = lui|auipc|jal|jalr|load|op-imm|op.
- brh = jal | jalr | branch & one of:
  - f3 0: is_zero; f3 1: !is_zero.
  - f3 4: is_lt; f3 5: !is_lt.
  - f3 6: is_ltu; f3 7: !is_ltu.
  - f3 2 and 3 never take the branch.
- brh_addr = ((jalr ? qa : pc) + imm) with bit 0 cleared.
  - Addition is modulo 2^32.
  - brh_addr is valid even when brh = 0.

## Timing
- Fully combinational; zero-cycle latency; no internal state.
- While rst = 0, the following are forced to 0 asynchronously: brh, alu_op, mem_op, reg_we, load, store.
- While rst = 0, the data outputs (brh_addr, alu_imm_*, alu_src_*) still follow their inputs.
- Release of rst takes effect immediately, with no cycle delay.

## Structure
- Shared package holds:
  - Opcode[6:2] constants.
  - alu_op bit/select constants.
  - mem_op bit constants.
- One natural sub-module: rv32_imm_gen, covering the five immediate formats and their type-select.
- The branch-target adder and control logic live in the top-level block.

## Test plan
- add/sub:
  - rst = 1, inst 0x002081B3 → alu_op 0x03, alu_src_1 = alu_src_2 = 1, reg_we 1, mem_op 0, brh 0.
  - inst 0x402081B3 → alu_op 0x02.
- lw: inst 0x0080A283 → load 1, mem_op 0x20, alu_op 0x03, alu_imm_2 0x8, alu_src_1 1, alu_src_2 0, reg_we 1.
- jal: pc 0x100, inst 0x010000EF → brh 1, brh_addr 0x110, alu_imm_1 0x100, alu_imm_2 4, reg_we 1.
- jalr: inst 0x00508067, qa 0x200 → brh 1, brh_addr 0x204 (bit 0 cleared).
- beq: pc 0x40, inst 0xFE208CE3 → brh_addr 0x38, alu_op 0x02, reg_we 0; brh 1 when is_zero = 1, brh 0 when is_zero = 0.
  - Repeat with f3 = 4/5/6/7 against is_lt/is_ltu both polarities.
- Reset: rst = 0 with the jal stimulus → brh, alu_op, mem_op, reg_we, load, store all 0; brh_addr still 0x110.
  - Deassert rst → values restore without a clock edge.
